// File: rtl/vga_timing_gen_if.sv
// Raster/sync bundle between the timing generator and the screen painter.
interface vga_timing_gen_if;
   logic       pix_tick;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       vid_on;
   logic       line_start;
   logic       frame_start;
   logic       hsync;
   logic       vsync;

   modport master (
      output pix_tick, pixel_x, pixel_y, vid_on,
             line_start, frame_start, hsync, vsync
   );

   modport slave (
      input  pix_tick, pixel_x, pixel_y, vid_on,
             line_start, frame_start, hsync, vsync
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, x/y counters, visible flag,
// line/frame pulses and active-low syncs delayed to match painter latency.
module vga_timing_gen #(
   parameter int CLK_DIV    = 4,
   parameter int H_VISIBLE  = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_DELAY = 2
) (
   input  logic              clk,
   input  logic              rst,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [3:0] div_cnt;
   logic       pix_tick;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic [9:0] x_nxt;
   logic [9:0] y_nxt;
   logic       x_wrap;
   logic       y_wrap;
   logic       vid_on;
   logic       line_start;
   logic       frame_start;
   logic       hsync_raw;
   logic       vsync_raw;
   logic       hsync;
   logic       vsync;

   // Pixel-rate divider; the strobe is registered so it is glitch-free for the painter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt  <= '0;
         pix_tick <= 1'b0;
      end else begin
         pix_tick <= (div_cnt == DIV_LAST);
         div_cnt  <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      end
   end

   // Next raster position, so all decoded flags can be registered alongside the counters.
   always_comb begin
      x_wrap = (pixel_x == H_LAST);
      y_wrap = (pixel_y == V_LAST);
      x_nxt  = pixel_x;
      y_nxt  = pixel_y;
      if (pix_tick) begin
         if (x_wrap) begin
            x_nxt = '0;
            y_nxt = y_wrap ? 10'd0 : pixel_y + 10'd1;
         end else begin
            x_nxt = pixel_x + 10'd1;
         end
      end
   end

   // Raster counters plus flags decoded from the next position, keeping them cycle-aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pixel_x     <= '0;
         pixel_y     <= '0;
         vid_on      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         hsync_raw   <= 1'b1;
         vsync_raw   <= 1'b1;
      end else begin
         pixel_x     <= x_nxt;
         pixel_y     <= y_nxt;
         vid_on      <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
         line_start  <= pix_tick && x_wrap;
         frame_start <= pix_tick && x_wrap && y_wrap;
         hsync_raw   <= !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
         vsync_raw   <= !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
      end
   end

   generate
      if (SYNC_DELAY == 0) begin : g_no_dly
         assign hsync = hsync_raw;
         assign vsync = vsync_raw;
      end else begin : g_dly
         logic [SYNC_DELAY-1:0] hs_sr;
         logic [SYNC_DELAY-1:0] vs_sr;

         // Sync delay line runs at clk rate so the skew is in clk cycles, not pixels.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               hs_sr <= '1;
               vs_sr <= '1;
            end else begin
               hs_sr[0] <= hsync_raw;
               vs_sr[0] <= vsync_raw;
               for (int i = 1; i < SYNC_DELAY; i++) begin
                  hs_sr[i] <= hs_sr[i-1];
                  vs_sr[i] <= vs_sr[i-1];
               end
            end
         end

         assign hsync = hs_sr[SYNC_DELAY-1];
         assign vsync = vs_sr[SYNC_DELAY-1];
      end
   endgenerate

   assign vga.pix_tick    = pix_tick;
   assign vga.pixel_x     = pixel_x;
   assign vga.pixel_y     = pixel_y;
   assign vga.vid_on      = vid_on;
   assign vga.line_start  = line_start;
   assign vga.frame_start = frame_start;
   assign vga.hsync       = hsync;
   assign vga.vsync       = vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against
// a closed-form raster model, plus directed literal checks.
module tb_vga_timing_gen;

   logic clk;
   logic rst;
   int   t;
   int   checks;
   int   errors;
   bit   run_cmp;

   typedef struct packed {
      logic       tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       vid;
      logic       ls;
      logic       fs;
      logic       hs;
      logic       vs;
   } exp_t;

   vga_timing_gen_if if_def ();
   vga_timing_gen_if if_fast ();
   vga_timing_gen_if if_mid ();

   vga_timing_gen u_def (
      .clk (clk),
      .rst (rst),
      .vga (if_def)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(0)
   ) u_fast (
      .clk (clk),
      .rst (rst),
      .vga (if_fast)
   );

   vga_timing_gen #(
      .CLK_DIV(3), .H_VISIBLE(10), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_VISIBLE(5), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(5)
   ) u_mid (
      .clk (clk),
      .rst (rst),
      .vga (if_mid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Clk edges since reset release; 0 while in reset.
   always @(posedge clk or negedge rst) begin
      if (!rst) t <= 0;
      else      t <= t + 1;
   end

   // Expected outputs after edge t since release, from raster arithmetic.
   function automatic exp_t model(input int te, input int d,
                                  input int hv, input int hfp, input int hsw, input int hbp,
                                  input int vv, input int vfp, input int vsw, input int vbp,
                                  input int sd);
      exp_t e;
      int ht, vt, n, pos, x, y, tr;
      e    = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (te < 1) return e;
      ht     = hv + hfp + hsw + hbp;
      vt     = vv + vfp + vsw + vbp;
      n      = (te - 1) / d;
      pos    = n % (ht * vt);
      x      = pos % ht;
      y      = pos / ht;
      e.tick = ((te % d) == 0);
      e.x    = 10'(x);
      e.y    = 10'(y);
      e.vid  = (x < hv) && (y < vv);
      e.ls   = (n > 0) && (((te - 1) % d) == 0) && (x == 0);
      e.fs   = e.ls && (y == 0);
      tr     = te - sd;
      if (tr >= 1) begin
         n    = (tr - 1) / d;
         pos  = n % (ht * vt);
         x    = pos % ht;
         y    = pos / ht;
         e.hs = !((x >= hv + hfp) && (x < hv + hfp + hsw));
         e.vs = !((y >= vv + vfp) && (y < vv + vfp + vsw));
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s t=%0d actual=%0h required=%0h", nm, t, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   exp_t a_def, a_fast, a_mid;

   // Every-cycle comparison of all three instances against the model.
   always @(negedge clk) begin
      if (run_cmp) begin
         a_def  = {if_def.pix_tick, if_def.pixel_x, if_def.pixel_y, if_def.vid_on,
                   if_def.line_start, if_def.frame_start, if_def.hsync, if_def.vsync};
         a_fast = {if_fast.pix_tick, if_fast.pixel_x, if_fast.pixel_y, if_fast.vid_on,
                   if_fast.line_start, if_fast.frame_start, if_fast.hsync, if_fast.vsync};
         a_mid  = {if_mid.pix_tick, if_mid.pixel_x, if_mid.pixel_y, if_mid.vid_on,
                   if_mid.line_start, if_mid.frame_start, if_mid.hsync, if_mid.vsync};
         chk("model_def", 32'(a_def),
             32'(model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33, 2)));
         chk("model_fast", 32'(a_fast),
             32'(model(t, 1, 8, 2, 3, 3, 4, 1, 2, 1, 0)));
         chk("model_mid", 32'(a_mid),
             32'(model(t, 3, 10, 2, 4, 2, 5, 2, 2, 3, 5)));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int cnt;
      t       = 0;
      checks  = 0;
      errors  = 0;
      rst     = 1'b0;
      run_cmp = 1'b1;

      repeat (10) @(posedge clk);
      #1;
      chk("rst_pixel_x", 32'(if_def.pixel_x), 0);
      chk("rst_vid_on", 32'(if_def.vid_on), 0);
      chk("rst_hsync", 32'(if_def.hsync), 1);
      chk("rst_vsync_mid", 32'(if_mid.vsync), 1);
      @(negedge clk);
      rst = 1'b1;

      step();
      chk("e1_vid_on", 32'(if_def.vid_on), 1);
      chk("e1_pixel_x", 32'(if_def.pixel_x), 0);
      chk("e1_tick", 32'(if_def.pix_tick), 0);
      chk("e1_line_start", 32'(if_def.line_start), 0);
      chk("e1_fast_tick", 32'(if_fast.pix_tick), 1);
      chk("e1_fast_frame_start", 32'(if_fast.frame_start), 0);
      step();
      chk("e2_tick", 32'(if_def.pix_tick), 0);
      chk("e2_fast_x", 32'(if_fast.pixel_x), 1);
      step();
      chk("e3_tick", 32'(if_def.pix_tick), 0);
      chk("e3_fast_x", 32'(if_fast.pixel_x), 2);
      step();
      chk("e4_tick", 32'(if_def.pix_tick), 1);
      chk("e4_pixel_x", 32'(if_def.pixel_x), 0);
      step();
      chk("e5_tick", 32'(if_def.pix_tick), 0);
      chk("e5_pixel_x", 32'(if_def.pixel_x), 1);
      repeat (36) step();
      chk("e41_pixel_x", 32'(if_def.pixel_x), 10);

      // fast instance: frame wrap and vsync window
      for (k = 0; k < 300; k++) begin
         if (if_fast.pixel_x == 10'd15 && if_fast.pixel_y == 10'd7) break;
         step();
      end
      chk("fast_reach_last_x", 32'(if_fast.pixel_x), 15);
      step();
      chk("fast_wrap_x", 32'(if_fast.pixel_x), 0);
      chk("fast_wrap_y", 32'(if_fast.pixel_y), 0);
      chk("fast_frame_start", 32'(if_fast.frame_start), 1);
      chk("fast_line_start", 32'(if_fast.line_start), 1);
      step();
      chk("fast_frame_start_off", 32'(if_fast.frame_start), 0);
      for (k = 0; k < 300; k++) begin
         if (if_fast.pixel_y == 10'd5) break;
         step();
      end
      chk("fast_vsync_y5", 32'(if_fast.vsync), 0);
      for (k = 0; k < 300; k++) begin
         if (if_fast.pixel_y == 10'd7) break;
         step();
      end
      chk("fast_vsync_y7", 32'(if_fast.vsync), 1);

      // hsync window on line 0 of the default instance
      for (k = 0; k < 5000; k++) begin
         if (if_def.pixel_x == 10'd656) break;
         step();
      end
      chk("reach_x656", 32'(if_def.pixel_x), 656);
      chk("reach_x656_y", 32'(if_def.pixel_y), 0);
      chk("hs_before_fall", 32'(if_def.hsync), 1);
      cnt = 0;
      while (if_def.hsync !== 1'b0 && cnt < 50) begin
         step();
         cnt++;
      end
      chk("hs_fall_delay", cnt, 2);
      cnt = 0;
      while (if_def.hsync !== 1'b1 && cnt < 1000) begin
         step();
         cnt++;
      end
      chk("hs_low_width", cnt, 384);

      // line wrap from (799,5)
      for (k = 0; k < 30000; k++) begin
         if (if_def.pixel_x == 10'd640 && if_def.pixel_y == 10'd5) break;
         step();
      end
      chk("reach_x640", 32'(if_def.pixel_x), 640);
      chk("vid_off_x640", 32'(if_def.vid_on), 0);
      for (k = 0; k < 1000; k++) begin
         if (if_def.pixel_x == 10'd799) break;
         step();
      end
      chk("reach_x799", 32'(if_def.pixel_x), 799);
      chk("vid_off_x799", 32'(if_def.vid_on), 0);
      for (k = 0; k < 10; k++) begin
         if (if_def.pix_tick) break;
         step();
      end
      step();
      chk("lw_x", 32'(if_def.pixel_x), 0);
      chk("lw_y", 32'(if_def.pixel_y), 6);
      chk("lw_line_start", 32'(if_def.line_start), 1);
      chk("lw_vid_on", 32'(if_def.vid_on), 1);
      step();
      chk("lw_line_start_off", 32'(if_def.line_start), 0);

      // reset mid-line with a low hsync in the delay line
      for (k = 0; k < 5000; k++) begin
         if (if_def.pixel_x == 10'd656) break;
         step();
      end
      chk("mr_reach_x656", 32'(if_def.pixel_x), 656);
      step();
      chk("mr_hsync_before", 32'(if_def.hsync), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("mr_hsync", 32'(if_def.hsync), 1);
      chk("mr_pixel_x", 32'(if_def.pixel_x), 0);
      chk("mr_pixel_y", 32'(if_def.pixel_y), 0);
      chk("mr_vid_on", 32'(if_def.vid_on), 0);
      chk("mr_mid_pixel_y", 32'(if_mid.pixel_y), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("mr_no_stale_hsync", 32'(if_def.hsync), 1);
      end
      repeat (3200) step();

      run_cmp = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
